orientation_hist_accum: RTL
===========================

ORIENTATION_HIST_ACCUM -- requirements
Module: orientation_hist_accum

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter LANES, default 16, SHALL set the number of samples per input beat.
REQ-003 Parameter ANG_W, default 9, SHALL set the orientation field width.
REQ-004 Parameter MAG_W, default 9, SHALL set the magnitude field width.
REQ-005 Parameter NBINS, default 8, SHALL set the number of orientation bins.
REQ-006 Parameter BIN_SPAN, default 45, SHALL set the angular width of each bin.
REQ-007 Parameter ACC_W, default 16, SHALL set the width of each bin accumulator.
REQ-008 Port iclk, input, 1, SHALL be the rising-edge clock.
REQ-009 Port ireset, input, 1, SHALL be the synchronous active-high reset.
REQ-010 Port ivalid, input, 1, SHALL qualify idata and ilast.
REQ-011 Port ilast, input, 1, SHALL mark the final beat of a window.
REQ-012 Port idata, input, LANES*(ANG_W+MAG_W), SHALL carry lane k in bits [k*(ANG_W+MAG_W) +: ANG_W+MAG_W], angle in the upper ANG_W bits and magnitude in the lower MAG_W bits.
REQ-013 Port ohist, output, NBINS*ACC_W, SHALL carry bin b in bits [b*ACC_W +: ACC_W].
REQ-014 Port ovalid, output, 1, SHALL pulse for one cycle when ohist is updated.
REQ-015 Port obusy, output, 1, SHALL be high while a window is open or results are in flight.

Function
REQ-016 Lane k SHALL contribute its magnitude to bin b iff b*BIN_SPAN <= angle < (b+1)*BIN_SPAN; angles >= NBINS*BIN_SPAN SHALL contribute to no bin.
REQ-017 Stage 1 SHALL register the masked per-lane, per-bin magnitudes.
REQ-018 Stage 2 SHALL register the per-bin beat sum at width MAG_W+clog2(LANES), with no overflow.
REQ-019 Stage 3 SHALL load the beat sum into the accumulator on the first beat of a window and add it on subsequent beats.
REQ-020 Window tracking SHALL use a two-state FSM: IDLE -> OPEN on ivalid & !ilast; OPEN -> IDLE on ivalid & ilast; ivalid & ilast in IDLE SHALL form a one-beat window that stays in IDLE.
REQ-021 The first/last flags SHALL be pipelined alongside the data so that they align with stage 3.
REQ-022 ovalid SHALL assert exactly 3 cycles after the ilast beat is sampled, and ohist SHALL present the final sums from that cycle onward.
REQ-023 ohist SHALL hold its value until the next ovalid.
REQ-024 Cycles with ivalid low SHALL leave all accumulators unchanged; gaps inside a window are legal.
REQ-025 A new window SHALL be accepted the cycle after ilast, with no bubble required.
REQ-026 The internal accumulators SHALL be separate from the ohist register, so that back-to-back windows do not corrupt ohist.
REQ-027 obusy SHALL be high in OPEN and while any pipeline stage holds a valid beat.

Reset
REQ-028 On ireset, ohist, ovalid, obusy, all pipeline registers and the accumulators SHALL go to 0, and the FSM SHALL go to IDLE.
REQ-029 A reset asserted mid-window SHALL discard the partial window and all in-flight beats, and no ovalid SHALL follow.

Configuration
REQ-030 With HIST_SATURATE_EN defined, each accumulator SHALL clamp at 2^ACC_W-1.
REQ-031 Without HIST_SATURATE_EN, each accumulator SHALL wrap modulo 2^ACC_W.

Structure
REQ-032 Package sift_desc_pkg SHALL hold the default parameter constants and a function that computes the beat-sum width.
REQ-033 Sub-module hist_bin_sum SHALL implement the stage 1 compare and the stage 2 adder tree for one bin, and SHALL be instantiated NBINS times.

Verification
REQ-034 One beat with ilast, all 16 lanes at angle 10 and magnitude 100 -> ovalid 3 cycles later; bin0=1600; all other bins 0.
REQ-035 One beat with lanes at angles 44, 45, 359, 360 and magnitude 7, other lanes at magnitude 0 -> bin0=7, bin1=7, bin7=7; angle 360 contributes nothing.
REQ-036 Four beats with ivalid gaps, lane0 at angle 90 and magnitude 511, other lanes at magnitude 0 -> bin2=2044 with exactly one ovalid.
REQ-037 Ten beats, all lanes at angle 0 and magnitude 511 -> bin0=65535 with HIST_SATURATE_EN, 16224 without.
REQ-038 Two back-to-back windows (bin3 sums 300, then 50) -> two ovalids 1 cycle apart, showing 300 then 50.
REQ-039 ireset asserted on beat 2 of a 4-beat window -> no ovalid, all outputs 0; the next window then yields correct sums.

Source files
------------

// File: rtl/sift_desc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sift_desc_pkg: default orientation-histogram constants, beat-sum width    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package sift_desc_pkg;

  localparam int DEF_LANES    = 16;
  localparam int DEF_ANG_W    = 9;
  localparam int DEF_MAG_W    = 9;
  localparam int DEF_NBINS    = 8;
  localparam int DEF_BIN_SPAN = 45;
  localparam int DEF_ACC_W    = 16;

  // Width that holds LANES full-scale magnitudes without overflow.
  function automatic int beat_sum_w(input int mag_w, input int lanes);
    return mag_w + $clog2(lanes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hist_bin_sum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hist_bin_sum: per-bin angle mask (stage 1) and lane adder tree (stage 2)  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hist_bin_sum
  import sift_desc_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ANG_W  = DEF_ANG_W,
  parameter int MAG_W  = DEF_MAG_W,
  parameter int BIN_LO = 0,
  parameter int BIN_HI = DEF_BIN_SPAN,
  parameter int SUM_W  = beat_sum_w(DEF_MAG_W, DEF_LANES)
) (
  input  logic                           iclk,
  input  logic                           ireset,
  input  logic [LANES*(ANG_W+MAG_W)-1:0] idata,
  output logic [SUM_W-1:0]               osum
);

  localparam int c_LANE_W = ANG_W + MAG_W;

  logic [MAG_W-1:0] w_masked [LANES];
  logic [MAG_W-1:0] r_masked [LANES];
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_sum;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_masked[k] = '0;
      if ((32'(idata[k*c_LANE_W+MAG_W +: ANG_W]) >= 32'(BIN_LO)) &&
          (32'(idata[k*c_LANE_W+MAG_W +: ANG_W]) <  32'(BIN_HI)))
        w_masked[k] = idata[k*c_LANE_W +: MAG_W];
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      for (int k = 0; k < LANES; k++) r_masked[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) r_masked[k] <= w_masked[k];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) w_sum = w_sum + SUM_W'(r_masked[k]);
  end

  always_ff @(posedge iclk) begin
    if (ireset) r_sum <= '0;
    else        r_sum <= w_sum;
  end

  assign osum = r_sum;

endmodule
`default_nettype wire

// File: rtl/orientation_hist_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | orientation_hist_accum: windowed orientation histogram, 3-stage pipeline  |
// | Option macro HIST_SATURATE_EN: clamp accumulators instead of wrapping.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module orientation_hist_accum
  import sift_desc_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int ANG_W    = DEF_ANG_W,
  parameter int MAG_W    = DEF_MAG_W,
  parameter int NBINS    = DEF_NBINS,
  parameter int BIN_SPAN = DEF_BIN_SPAN,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                           iclk,
  input  logic                           ireset,
  input  logic                           ivalid,
  input  logic                           ilast,
  input  logic [LANES*(ANG_W+MAG_W)-1:0] idata,
  output logic [NBINS*ACC_W-1:0]         ohist,
  output logic                           ovalid,
  output logic                           obusy
);

  localparam int c_SUM_W = beat_sum_w(MAG_W, LANES);
`ifdef HIST_SATURATE_EN
  localparam int c_ADD_W = ACC_W + 1;
`else
  localparam int c_ADD_W = ACC_W;
`endif

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_OPEN = 1'b1;

  logic [0:0]             r_state;
  logic                   r_v1, r_first1, r_last1;
  logic                   r_v2, r_first2, r_last2;
  logic [c_SUM_W-1:0]     w_sum     [NBINS];
  logic [c_ADD_W-1:0]     w_add     [NBINS];
  logic [ACC_W-1:0]       w_acc_nxt [NBINS];
  logic [ACC_W-1:0]       r_acc     [NBINS];
  logic [NBINS*ACC_W-1:0] r_hist;
  logic                   r_ovalid;

  always_ff @(posedge iclk) begin
    if (ireset)      r_state <= c_ST_IDLE;
    else if (ivalid) r_state <= ilast ? c_ST_IDLE : c_ST_OPEN;
  end

  // First/last flags travel with the data so they line up with stage 3.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_v1 <= 1'b0; r_first1 <= 1'b0; r_last1 <= 1'b0;
      r_v2 <= 1'b0; r_first2 <= 1'b0; r_last2 <= 1'b0;
    end else begin
      r_v1     <= ivalid;
      r_first1 <= ivalid & (r_state == c_ST_IDLE);
      r_last1  <= ivalid & ilast;
      r_v2     <= r_v1;
      r_first2 <= r_first1;
      r_last2  <= r_last1;
    end
  end

  for (genvar b = 0; b < NBINS; b++) begin : g_bin
    hist_bin_sum #(
      .LANES  (LANES),
      .ANG_W  (ANG_W),
      .MAG_W  (MAG_W),
      .BIN_LO (b * BIN_SPAN),
      .BIN_HI ((b + 1) * BIN_SPAN),
      .SUM_W  (c_SUM_W)
    ) u_sum (
      .iclk   (iclk),
      .ireset (ireset),
      .idata  (idata),
      .osum   (w_sum[b])
    );
  end

  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      w_add[b] = c_ADD_W'(r_acc[b]) + c_ADD_W'(w_sum[b]);
      if (r_first2)
        w_acc_nxt[b] = ACC_W'(w_sum[b]);
`ifdef HIST_SATURATE_EN
      else if (w_add[b][c_ADD_W-1])
        w_acc_nxt[b] = '1;
`endif
      else
        w_acc_nxt[b] = w_add[b][ACC_W-1:0];
    end
  end

  // ohist is a separate register so a following window cannot disturb it.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      for (int b = 0; b < NBINS; b++) r_acc[b] <= '0;
      r_hist   <= '0;
      r_ovalid <= 1'b0;
    end else begin
      r_ovalid <= r_v2 & r_last2;
      if (r_v2) begin
        for (int b = 0; b < NBINS; b++) r_acc[b] <= w_acc_nxt[b];
      end
      if (r_v2 & r_last2) begin
        for (int b = 0; b < NBINS; b++) r_hist[b*ACC_W +: ACC_W] <= w_acc_nxt[b];
      end
    end
  end

  assign ohist  = r_hist;
  assign ovalid = r_ovalid;
  assign obusy  = (r_state == c_ST_OPEN) | r_v1 | r_v2;

endmodule
`default_nettype wire
